lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WAIT_MAX, default 255: maximum bus cycles, counted from request issue, before timeout.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 memwrite  in  1  store request from control decode.
REQ-005 load  in  1  load request from control decode.
REQ-006 storeops  in  2  store width: 1=byte, 2=half, 3=word; 0 is invalid.
REQ-007 funct  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 addr  in  32  effective byte address from the ALU.
REQ-009 wdata  in  32  store data, right-justified.
REQ-010 stall  out  1  pipeline hold while an access is outstanding.
REQ-011 rdata  out  32  aligned and extended load result.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  one-cycle error pulse, coincident with done.
REQ-014 bus_req, bus_we  out  1 each  bus request and write select.
REQ-015 bus_addr  out  32  word address: {addr[31:2],2'b00}.
REQ-016 bus_wdata  out  32, bus_be  out  4  lane-replicated write data and byte enables.
REQ-017 bus_gnt, bus_rvalid  in  1 each, and bus_rdata  in  32: grant, read-data valid, and read data.

Function
REQ-018 The FSM SHALL have four states, IDLE, REQ, WAIT and DONE, and SHALL start in IDLE.
REQ-019 IDLE SHALL capture addr, wdata, storeops, funct and direction when load or memwrite is high, then enter REQ on the next edge.
REQ-020 When load and memwrite are both high, memwrite SHALL take priority.
REQ-021 stall SHALL be high combinationally in IDLE when a request is present, and in REQ and WAIT.
REQ-022 stall SHALL be low in DONE, so the pipeline advances on the done cycle.
REQ-023 In REQ, bus_req SHALL be high and all bus_* outputs SHALL be held stable until bus_gnt is sampled high.
REQ-024 A store granted in REQ SHALL go to DONE.
REQ-025 A load granted in REQ SHALL go to WAIT, or directly to DONE if bus_rvalid is high in the same cycle.
REQ-026 WAIT SHALL go to DONE on bus_rvalid, latching bus_rdata.
REQ-027 DONE SHALL pulse done for exactly one cycle and then return to IDLE; new requests are accepted only in IDLE.
REQ-028 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-029 storeops=0 SHALL set bus_be=0 and complete with err.
REQ-030 bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-031 rdata SHALL select the lane by captured addr[1:0] (half uses addr[1]).
REQ-032 rdata SHALL be sign-extended for LB and LH, zero-extended for LBU and LHU, and the full word for LW.
REQ-033 Any other funct SHALL yield rdata=0 with err.
REQ-034 rdata SHALL hold its value until the next load completes.
REQ-035 A cycle counter SHALL clear on entering REQ and increment in REQ and WAIT.
REQ-036 On reaching WAIT_MAX, the FSM SHALL drop bus_req and enter DONE with err; a bus_rvalid arriving afterward SHALL be ignored.

Reset
REQ-037 rst_n low SHALL asynchronously force IDLE, the counter to 0, and stall, done, err, bus_req and bus_we to 0.
REQ-038 rst_n low SHALL also force bus_addr, bus_wdata, bus_be and rdata to 0.
REQ-039 Reset mid-access SHALL abandon the transaction without issuing a done pulse.

Configuration
REQ-040 With LSU_MISALIGN_TRAP_EN defined, half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL skip REQ, issue no bus_req, and go to DONE with err.
REQ-041 Without LSU_MISALIGN_TRAP_EN, the low address bits SHALL be ignored: a half uses addr[1] only, and a word is forced aligned.

Verification
REQ-042 Store byte: addr=0x1003, wdata=0xAB, gnt after 2 cycles -> bus_be=1000, bus_wdata=0xABABABAB, done one cycle after gnt.
REQ-043 LB: addr=0x2001, rvalid with bus_rdata=0x0000_8000 -> rdata=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-044 Load with gnt and rvalid in the same cycle -> REQ to DONE directly, and stall spans exactly 2 cycles after IDLE.
REQ-045 WAIT_MAX=4, gnt never asserted -> bus_req drops after 4 cycles, and done=err=1.
REQ-046 LSU_MISALIGN_TRAP_EN, SW at 0x2002 -> no bus_req, err pulse; without the macro -> bus_addr=0x2000, bus_be=1111.
REQ-047 rst_n asserted while in WAIT -> all outputs 0 immediately, no done pulse, and the next request is served normally.

Source files
------------

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module  : lsu
// Brief   : Load/store unit. It drives a req/gnt/rvalid bus, handles byte/half/word
//           lanes, sign extension and a request timeout.
//           Optional macro LSU_MISALIGN_TRAP_EN makes misaligned half/word
//           accesses trap.
// Revision: 1.0 - initial release
// ============================================================================
module lsu #(
   parameter int WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memwrite,
   input  logic        load,
   input  logic [1:0]  storeops,
   input  logic [2:0]  funct,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);
   localparam int            CW       = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    lane_q, lane_d;
   logic [2:0]    funct_q, funct_d;
   logic          we_q, we_d;
   logic          bad_q, bad_d;
   logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic          done_q, done_d, err_q, err_d;
   logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
   logic [3:0]    bus_be_q, bus_be_d;

   logic [31:0]   ld_data;
   logic          ld_err;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic          misalign;
   logic          timeout;

   always_comb begin
      ld_byte = 8'(bus_rdata >> {lane_q, 3'b000});
      ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ld_err  = 1'b0;
      case (funct_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = bus_rdata;
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: begin
            ld_data = 32'd0;
            ld_err  = 1'b1;
         end
      endcase
   end

   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = memwrite ? ((storeops == 2'd2 && addr[0]) || (storeops == 2'd3 && addr[1:0] != 2'b00))
                          : ((funct[1:0] == 2'b01 && addr[0]) || (funct[1:0] == 2'b10 && addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   assign timeout = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lane_d      = lane_q;
      funct_d     = funct_q;
      we_d        = we_q;
      bad_d       = bad_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: if (memwrite || load) begin
            lane_d      = addr[1:0];
            funct_d     = funct;
            we_d        = memwrite;
            bad_d       = memwrite && (storeops == 2'd0);
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = 32'd0;
            bus_be_d    = 4'b1111;
            if (memwrite) begin
               case (storeops)
                  2'd1: begin
                     bus_be_d    = 4'b0001 << addr[1:0];
                     bus_wdata_d = {4{wdata[7:0]}};
                  end
                  2'd2: begin
                     bus_be_d    = 4'b0011 << {addr[1], 1'b0};
                     bus_wdata_d = {2{wdata[15:0]}};
                  end
                  2'd3: begin
                     bus_be_d    = 4'b1111;
                     bus_wdata_d = wdata;
                  end
                  default: begin
                     bus_be_d    = 4'b0000;
                     bus_wdata_d = wdata;
                  end
               endcase
            end
            // A trapped access never touches the bus and completes straight away.
            if (misalign) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               state_d   = REQ;
               bus_req_d = 1'b1;
               bus_we_d  = memwrite;
               cnt_d     = '0;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (bus_gnt) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               if (we_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = bad_q;
               end else if (bus_rvalid) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = ld_err;
                  rdata_d = ld_data;
               end else begin
                  state_d = WAIT;
               end
            end else if (timeout) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (bus_rvalid) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = ld_err;
               rdata_d = ld_data;
            end else if (timeout) begin
               state_d = DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lane_q      <= 2'd0;
         funct_q     <= 3'd0;
         we_q        <= 1'b0;
         bad_q       <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_be_q    <= 4'd0;
         rdata_q     <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lane_q      <= lane_d;
         funct_q     <= funct_d;
         we_q        <= we_d;
         bad_q       <= bad_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign stall     = rst_n && ((state_q == IDLE && (load || memwrite)) ||
                                state_q == REQ || state_q == WAIT);
   assign rdata     = rdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_be    = bus_be_q;

endmodule
`default_nettype wire
